// File: rtl/mult_product_accumulator.sv
// Multiply-accumulate back end: sums a programmable-length frame of 8-bit products,
// then drains the ACC_W-bit result LSB byte first over a valid/ready byte port.
module mult_product_accumulator #(
    parameter int unsigned ACC_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       clear,
    input  logic [3:0] frame_len,
    input  logic [7:0] prod_in,
    input  logic       prod_valid,
    output logic       prod_ready,
    output logic [7:0] out_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       overflow
);

    localparam int unsigned NBYTES = (ACC_W + 7) / 8;

    typedef enum logic {
        ACCUM,
        DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [4:0]       len_q, len_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W:0]   sum;
    logic [4:0]       eff_len;
    logic [4:0]       cnt_inc;
    logic [31:0]      acc_ext;
    logic             last_byte;

    always_comb begin
        sum       = {1'b0, acc_q} + (ACC_W+1)'(prod_in);
        cnt_inc   = cnt_q + 5'd1;
        // The first product of a frame must see its own freshly sampled length.
        eff_len   = (cnt_q == '0) ? ((frame_len == '0) ? 5'd16 : {1'b0, frame_len}) : len_q;
        acc_ext   = '0;
        acc_ext[ACC_W-1:0] = acc_q;
        last_byte = (byte_idx_q == 2'(NBYTES - 1));

        prod_ready = 1'b0;
        out_valid  = 1'b0;
        out_byte   = '0;
        out_last   = 1'b0;
        overflow   = 1'b0;
        if (state_q == ACCUM) begin
            prod_ready = rst_n & ena & ~clear;
        end else begin
            out_valid = rst_n & ena;
            out_byte  = acc_ext[{byte_idx_q, 3'b000} +: 8];
            out_last  = last_byte;
            overflow  = ovf_q;
        end

        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        byte_idx_d = byte_idx_q;
        ovf_d      = ovf_q;

        if (clear) begin
            state_d    = ACCUM;
            acc_d      = '0;
            cnt_d      = '0;
            byte_idx_d = '0;
            ovf_d      = 1'b0;
        end else if (ena) begin
            case (state_q)
                ACCUM: begin
                    if (prod_valid) begin
                        acc_d = sum[ACC_W-1:0];
                        ovf_d = ovf_q | sum[ACC_W];
                        cnt_d = cnt_inc;
                        if (cnt_q == '0) begin
                            len_d = eff_len;
                        end
                        if (cnt_inc == eff_len) begin
                            state_d    = DRAIN;
                            byte_idx_d = '0;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (last_byte) begin
                            state_d    = ACCUM;
                            acc_d      = '0;
                            cnt_d      = '0;
                            ovf_d      = 1'b0;
                            byte_idx_d = '0;
                        end else begin
                            byte_idx_d = byte_idx_q + 2'd1;
                        end
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            byte_idx_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            byte_idx_q <= byte_idx_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Scoreboard bench: stimulus pushes expected bytes, monitors pop and compare on each transfer.
module tb_mult_product_accumulator;

    typedef struct packed {
        logic [7:0] b;
        logic       last;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena, clear, prod_valid, out_ready;
    logic [3:0] frame_len;
    logic [7:0] prod_in;
    logic       prod_ready, out_valid, out_last, overflow;
    logic [7:0] out_byte;

    logic       ena8, clear8, prod_valid8, out_ready8;
    logic [3:0] frame_len8;
    logic [7:0] prod_in8;
    logic       prod_ready8, out_valid8, out_last8, overflow8;
    logic [7:0] out_byte8;

    exp_t q[$];
    exp_t q8[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mult_product_accumulator dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .frame_len(frame_len),
        .prod_in(prod_in), .prod_valid(prod_valid), .prod_ready(prod_ready),
        .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .overflow(overflow)
    );

    mult_product_accumulator #(.ACC_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena8), .clear(clear8), .frame_len(frame_len8),
        .prod_in(prod_in8), .prod_valid(prod_valid8), .prod_ready(prod_ready8),
        .out_byte(out_byte8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out_last(out_last8), .overflow(overflow8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) chk("prod_ready_low_in_drain", {31'd0, prod_ready}, 32'd0);
        if (rst_n && out_valid && out_ready) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_byte: got 0x%0h with nothing expected", out_byte);
            end else begin
                e = q.pop_front();
                if (out_byte !== e.b || out_last !== e.last || overflow !== e.ovf) begin
                    n_fail++;
                    $display("FAIL out_byte: got byte=0x%0h last=%0b ovf=%0b, expected byte=0x%0h last=%0b ovf=%0b",
                             out_byte, out_last, overflow, e.b, e.last, e.ovf);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid8 && out_ready8) begin
            n_checks++;
            if (q8.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_byte8: got 0x%0h with nothing expected", out_byte8);
            end else begin
                e = q8.pop_front();
                if (out_byte8 !== e.b || out_last8 !== e.last || overflow8 !== e.ovf) begin
                    n_fail++;
                    $display("FAIL out_byte8: got byte=0x%0h last=%0b ovf=%0b, expected byte=0x%0h last=%0b ovf=%0b",
                             out_byte8, out_last8, overflow8, e.b, e.last, e.ovf);
                end
            end
        end
    end

    task automatic expect_byte(input logic [7:0] b, input logic last, input logic ovf);
        q.push_back('{b: b, last: last, ovf: ovf});
    endtask

    task automatic send(input logic [7:0] p);
        int t = 0;
        @(negedge clk);
        prod_in    = p;
        prod_valid = 1'b1;
        while (!prod_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1 prod_valid = 1'b0;
    endtask

    task automatic send8(input logic [7:0] p);
        int t = 0;
        @(negedge clk);
        prod_in8    = p;
        prod_valid8 = 1'b1;
        while (!prod_ready8 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("send8_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1 prod_valid8 = 1'b0;
    endtask

    task automatic drain_wait();
        int t = 0;
        while ((q.size() != 0 || q8.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk("drain_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1; clear = 1'b0; prod_valid = 1'b0; out_ready = 1'b1;
        frame_len = 4'd0; prod_in = 8'h00;
        ena8 = 1'b1; clear8 = 1'b0; prod_valid8 = 1'b0; out_ready8 = 1'b1;
        frame_len8 = 4'd0; prod_in8 = 8'h00;
        #12;
        chk("rst_prod_ready", {31'd0, prod_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_byte", {24'd0, out_byte}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("post_rst_prod_ready", {31'd0, prod_ready}, 32'd1);

        // 0x0F + 0xE1 + 0x64 = 0x154
        frame_len = 4'd3;
        expect_byte(8'h54, 1'b0, 1'b0);
        expect_byte(8'h01, 1'b1, 1'b0);
        send(8'h0F);
        send(8'hE1);
        chk("pre_last_out_valid", {31'd0, out_valid}, 32'd0);
        send(8'h64);
        chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
        drain_wait();

        // 16 x 0xE1 = 0xE10
        frame_len = 4'd0;
        expect_byte(8'h10, 1'b0, 1'b0);
        expect_byte(8'h0E, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) send(8'hE1);
        drain_wait();

        // Backpressure holds the first byte and blocks new products
        frame_len = 4'd1;
        out_ready = 1'b0;
        send(8'h2A);
        prod_in = 8'h55;
        prod_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_out_byte", {24'd0, out_byte}, 32'h2A);
            chk("bp_out_last", {31'd0, out_last}, 32'd0);
        end
        @(posedge clk);
        #1 prod_valid = 1'b0;
        expect_byte(8'h2A, 1'b0, 1'b0);
        expect_byte(8'h00, 1'b1, 1'b0);
        out_ready = 1'b1;
        drain_wait();
        expect_byte(8'h55, 1'b0, 1'b0);
        expect_byte(8'h00, 1'b1, 1'b0);
        send(8'h55);
        drain_wait();

        // Clear mid-frame discards the partial sum
        frame_len = 4'd4;
        send(8'h11);
        send(8'h22);
        @(posedge clk);
        #1 clear = 1'b1;
        #1 chk("clear_prod_ready", {31'd0, prod_ready}, 32'd0);
        @(posedge clk);
        #1 clear = 1'b0;
        frame_len = 4'd1;
        expect_byte(8'h09, 1'b0, 1'b0);
        expect_byte(8'h00, 1'b1, 1'b0);
        send(8'h09);
        drain_wait();

        // ena low freezes the frame: 0x05 + 0x06 + 0x07 = 0x12, the 0x77 is never taken
        frame_len = 4'd3;
        send(8'h05);
        @(negedge clk);
        ena = 1'b0;
        prod_in = 8'h77;
        prod_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("ena_low_prod_ready", {31'd0, prod_ready}, 32'd0);
            @(negedge clk);
        end
        prod_valid = 1'b0;
        ena = 1'b1;
        expect_byte(8'h12, 1'b0, 1'b0);
        expect_byte(8'h00, 1'b1, 1'b0);
        send(8'h06);
        send(8'h07);
        drain_wait();

        // Reset in the middle of a drain
        frame_len = 4'd1;
        out_ready = 1'b0;
        send(8'h33);
        chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_prod_ready", {31'd0, prod_ready}, 32'd0);
        chk("midrst_overflow", {31'd0, overflow}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        #1 chk("rerst_prod_ready", {31'd0, prod_ready}, 32'd1);
        expect_byte(8'h44, 1'b0, 1'b0);
        expect_byte(8'h00, 1'b1, 1'b0);
        send(8'h44);
        drain_wait();

        // ACC_W=8: 0xC8 + 0x64 = 0x12C wraps to 0x2C with overflow
        frame_len8 = 4'd2;
        q8.push_back('{b: 8'h2C, last: 1'b1, ovf: 1'b1});
        send8(8'hC8);
        send8(8'h64);
        drain_wait();
        frame_len8 = 4'd1;
        q8.push_back('{b: 8'h01, last: 1'b1, ovf: 1'b0});
        send8(8'h01);
        drain_wait();

        chk("queue_empty", q.size() + q8.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
